// File: rtl/apb_master_bridge_n.sv
// APB master bridge: one CPU request at a time onto one of NSLV slaves.
// Supports wait states, PSLVERR, bad-select rejection and an ACCESS timeout.
module apb_master_bridge_n #(
  parameter int AW      = 8,
  parameter int DW      = 21,
  parameter int NSLV    = 4,
  parameter int SW      = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [SW-1:0]      req_sel,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [NSLV-1:0]    PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PWDATA,
  input  logic [NSLV*DW-1:0] PRDATA,
  input  logic [NSLV-1:0]    PREADY,
  input  logic [NSLV-1:0]    PSLVERR
);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } st_t;

  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TM1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TEN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TLAST = CW'(TM1);
  localparam logic [SW:0]   NS    = (SW+1)'(NSLV);

  st_t st, nst;

  logic            wr_q;
  logic [SW-1:0]   sel_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rd_q;
  logic            err_q;
  logic            to_q;
  logic [CW-1:0]   cnt_q;

  logic            bad;
  logic            acc;
  logic            tmo;
  logic            rdy_s;
  logic            err_s;
  logic [DW-1:0]   rdat_s;
  logic [NSLV-1:0] onehot;

  assign bad = {1'b0, req_sel} >= NS;
  assign acc = req_valid && (st == IDLE);
  assign tmo = TEN && (cnt_q == TLAST);

  // Only the selected slave's response lines are ever looked at.
  always_comb begin
    onehot = '0;
    rdy_s  = 1'b0;
    err_s  = 1'b0;
    rdat_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == SW'(i)) begin
        onehot[i] = 1'b1;
        rdy_s     = PREADY[i];
        err_s     = PSLVERR[i];
        rdat_s    = PRDATA[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) st <= IDLE;
    else        st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:    if (req_valid) nst = bad ? RESP : SETUP;
      SETUP:   nst = ACCESS;
      ACCESS:  if (rdy_s || tmo) nst = RESP;
      RESP:    nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (st == IDLE);
    busy        = (st != IDLE);
    PENABLE     = (st == ACCESS);
    PSEL        = (st == SETUP || st == ACCESS) ? onehot : '0;
    PWRITE      = wr_q;
    PADDR       = addr_q;
    PWDATA      = wdata_q;
    rsp_valid   = (st == RESP);
    rsp_rdata   = (st == RESP) ? rd_q : '0;
    rsp_err     = (st == RESP) && err_q;
    rsp_timeout = (st == RESP) && to_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (acc) begin
        wr_q    <= req_write;
        sel_q   <= req_sel;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= '0;
        err_q   <= bad;
        to_q    <= 1'b0;
        cnt_q   <= '0;
      end
      if (st == ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
        // A ready slave wins over a timeout in the same cycle.
        if (rdy_s) begin
          rd_q  <= wr_q ? '0 : rdat_s;
          err_q <= err_s;
          to_q  <= 1'b0;
        end else if (tmo) begin
          rd_q  <= '0;
          err_q <= 1'b1;
          to_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge_n.sv
// Directed bench for apb_master_bridge_n.
// SW is widened to 3 so an out-of-range select can be issued.
module tb_apb_master_bridge_n;

  localparam int AW = 8;
  localparam int DW = 21;
  localparam int NSLV = 4;
  localparam int SW = 3;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [SW-1:0]      req_sel;
  logic [AW-1:0]      req_addr;
  logic [DW-1:0]      req_wdata;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               rsp_timeout;
  logic               busy;
  logic [NSLV-1:0]    PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PWDATA;
  logic [NSLV*DW-1:0] PRDATA;
  logic [NSLV-1:0]    PREADY;
  logic [NSLV-1:0]    PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_master_bridge_n #(
    .AW(AW), .DW(DW), .NSLV(NSLV), .SW(SW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(
    input  logic            w,
    input  logic [SW-1:0]   s,
    input  logic [AW-1:0]   a,
    input  logic [DW-1:0]   d,
    input  int              wt,
    input  logic [NSLV-1:0] noise,
    output int              gap,
    output int              lat,
    output int              nacc,
    output int              nset,
    output logic [DW-1:0]   rd,
    output logic            er,
    output logic            to,
    output logic            bus_ok
  );
    logic [NSLV-1:0] oh;
    logic [NSLV-1:0] ep;
    bit done;
    oh = (int'(s) < NSLV) ? (NSLV'(1) << s) : '0;
    req_write = w;
    req_sel   = s;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    gap = 0;
    while (!req_ready && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    lat = 0; nacc = 0; nset = 0;
    rd = '0; er = 1'b0; to = 1'b0;
    bus_ok = 1'b1; done = 1'b0;
    PREADY = noise & ~oh;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      ep = (busy && !rsp_valid) ? oh : '0;
      if (PSEL !== ep) bus_ok = 1'b0;
      if (ep != 0 && (PADDR !== a || PWRITE !== w || PWDATA !== d))
        bus_ok = 1'b0;
      if (PSEL != 0 && !PENABLE) nset++;
      if (PENABLE) nacc++;
      PREADY = (noise & ~oh) | ((PENABLE && nacc > wt) ? oh : '0);
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
        done = 1'b1;
      end
    end
    PREADY = '0;
    chk("rsp_seen", done, 1);
  endtask

  int gap, lat, nacc, nset;
  logic [DW-1:0] rd;
  logic er, to, ok;
  int k;
  logic seen;

  initial begin
    PRDATA = {21'h1F00F, 21'h0AAAA, 21'h0F0F0, 21'h12345};
    PREADY = '0; PSLVERR = '0;
    reset = 1'b0; req_valid = 1'b1;
    req_write = 1'b1; req_sel = 3'd2;
    req_addr = 8'h3C; req_wdata = 21'h1ABCD;
    repeat (3) @(negedge clk);
    chk("rst_psel", PSEL, 0);
    chk("rst_pen", PENABLE, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    xfer(1'b1, 3'd2, 8'h3C, 21'h1ABCD, 0, 4'b1011,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("wr_lat", lat, 3);
    chk("wr_bus", ok, 1);
    chk("wr_setup", nset, 1);
    chk("wr_nacc", nacc, 1);
    chk("wr_err", er, 0);
    chk("wr_rd", rd, 0);
    @(negedge clk);
    chk("wr_strobe1", rsp_valid, 0);

    xfer(1'b0, 3'd1, 8'h55, 21'h0, 3, 4'b1101,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("ws_lat", lat, 6);
    chk("ws_nacc", nacc, 4);
    chk("ws_bus", ok, 1);
    chk("ws_rd", rd, 21'h0F0F0);
    chk("ws_err", er, 0);

    PSLVERR = 4'b0001;
    xfer(1'b1, 3'd0, 8'h10, 21'h00001, 1, 4'b0000,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("se_err", er, 1);
    chk("se_to", to, 0);
    chk("se_rd", rd, 0);
    chk("se_lat", lat, 4);
    PSLVERR = 4'b1110;
    xfer(1'b0, 3'd0, 8'h11, 21'h0, 0, 4'b1110,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("oe_err", er, 0);
    chk("oe_rd", rd, 21'h12345);
    PSLVERR = '0;

    xfer(1'b0, 3'd5, 8'h20, 21'h0, 0, 4'b1111,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("bs_lat", lat, 1);
    chk("bs_bus", ok, 1);
    chk("bs_nacc", nacc, 0);
    chk("bs_err", er, 1);
    chk("bs_to", to, 0);
    chk("bs_rd", rd, 0);

    xfer(1'b0, 3'd3, 8'h80, 21'h0, 1000, 4'b0111,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("to_nacc", nacc, 16);
    chk("to_lat", lat, 18);
    chk("to_err", er, 1);
    chk("to_flag", to, 1);
    chk("to_rd", rd, 0);
    chk("to_bus", ok, 1);

    xfer(1'b0, 3'd3, 8'h81, 21'h0, 15, 4'b0000,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("tb_nacc", nacc, 16);
    chk("tb_err", er, 0);
    chk("tb_to", to, 0);
    chk("tb_rd", rd, 21'h1F00F);

    @(negedge clk);
    req_write = 1'b0; req_sel = 3'd1;
    req_addr = 8'h44; req_valid = 1'b1;
    k = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!PENABLE && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mr_access", PENABLE, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_psel", PSEL, 0);
    chk("mr_pen", PENABLE, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rspv", rsp_valid, 0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid | busy;
    end
    chk("mr_quiet", seen, 0);

    xfer(1'b0, 3'd0, 8'h01, 21'h0, 0, 4'b0000,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("bb0_rd", rd, 21'h12345);
    chk("bb0_lat", lat, 3);
    xfer(1'b0, 3'd3, 8'h02, 21'h0, 0, 4'b0111,
         gap, lat, nacc, nset, rd, er, to, ok);
    chk("bb1_gap", gap, 1);
    chk("bb1_lat", lat, 3);
    chk("bb1_rd", rd, 21'h1F00F);
    chk("bb1_bus", ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
